bank_cmd_sequencer: RTL and testbench

BANK_CMD_SEQUENCER -- requirements
Module: bank_cmd_sequencer

---
 rtl/bank_cmd_sequencer.sv | 155 +++++++++++++++
 tb/tb_bank_cmd_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/bank_cmd_sequencer.sv
// Single-request DRAM bank command sequencer: tracks open rows per bank and
// issues PRE/ACT/READ/WRITE with precharge and activation wait times.
module bank_cmd_sequencer #(
    parameter int BANK_GROUPS        = 4,
    parameter int BANKS_PER_GROUP    = 2,
    parameter int ROW_BITS           = 8,
    parameter int COL_BITS           = 4,
    parameter int ACTIVATION_LATENCY = 8,
    parameter int PRECHARGE_LATENCY  = 5,
    localparam int BG_W = (BANK_GROUPS > 1) ? $clog2(BANK_GROUPS) : 1,
    localparam int BK_W = (BANKS_PER_GROUP > 1) ? $clog2(BANKS_PER_GROUP) : 1
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                req_valid_in,
    output logic                req_ready_out,
    input  logic                req_write_in,
    input  logic [BG_W-1:0]     req_bank_group_in,
    input  logic [BK_W-1:0]     req_bank_in,
    input  logic [ROW_BITS-1:0] req_row_in,
    input  logic [COL_BITS-1:0] req_col_in,
    input  logic                cmd_ready,
    output logic                valid_out,
    output logic [2:0]          cmd_out,
    output logic [BG_W-1:0]     bank_group_out,
    output logic [BK_W-1:0]     bank_out,
    output logic [ROW_BITS-1:0] row_out,
    output logic [COL_BITS-1:0] col_out,
    output logic                done_out,
    output logic                busy_out
);

    localparam int NUM_BANKS = BANK_GROUPS * BANKS_PER_GROUP;
    localparam int IDX_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int MAX_LAT   = (ACTIVATION_LATENCY > PRECHARGE_LATENCY) ?
                               ACTIVATION_LATENCY : PRECHARGE_LATENCY;
    localparam int CNT_W     = $clog2(MAX_LAT + 1);

    localparam logic [2:0] CMD_NOP   = 3'b000;
    localparam logic [2:0] CMD_ACT   = 3'b001;
    localparam logic [2:0] CMD_READ  = 3'b010;
    localparam logic [2:0] CMD_WRITE = 3'b011;
    localparam logic [2:0] CMD_PRE   = 3'b100;

    typedef enum logic [2:0] {
        IDLE, PRECHARGE, WAIT_PRE, ACTIVATE, WAIT_ACT, ACCESS
    } state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt_q, cnt_nxt;
    logic [NUM_BANKS-1:0] open_q;
    logic [ROW_BITS-1:0]  open_row_q [NUM_BANKS];
    logic                 write_q;
    logic [IDX_W-1:0]     idx_q, req_idx;
    logic                 capture;

    assign req_ready_out = (state == IDLE) && !rst_in;
    assign busy_out      = (state != IDLE);
    assign capture       = req_valid_in && req_ready_out;
    assign req_idx       = IDX_W'(req_bank_group_in) * IDX_W'(BANKS_PER_GROUP)
                         + IDX_W'(req_bank_in);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt_q;
        valid_out = 1'b0;
        cmd_out   = CMD_NOP;
        done_out  = 1'b0;
        case (state)
            IDLE: begin
                if (capture) begin
                    if (!open_q[req_idx])                        state_nxt = ACTIVATE;
                    else if (open_row_q[req_idx] == req_row_in)  state_nxt = ACCESS;
                    else                                         state_nxt = PRECHARGE;
                end
            end
            PRECHARGE: begin
                valid_out = 1'b1;
                cmd_out   = CMD_PRE;
                if (cmd_ready) begin
                    // Counter holds remaining wait cycles; latency 1 skips the wait state.
                    cnt_nxt   = CNT_W'(PRECHARGE_LATENCY - 1);
                    state_nxt = (PRECHARGE_LATENCY > 1) ? WAIT_PRE : ACTIVATE;
                end
            end
            WAIT_PRE: begin
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_nxt   = '0;
                    state_nxt = ACTIVATE;
                end else begin
                    cnt_nxt = cnt_q - CNT_W'(1);
                end
            end
            ACTIVATE: begin
                valid_out = 1'b1;
                cmd_out   = CMD_ACT;
                if (cmd_ready) begin
                    cnt_nxt   = CNT_W'(ACTIVATION_LATENCY - 1);
                    state_nxt = (ACTIVATION_LATENCY > 1) ? WAIT_ACT : ACCESS;
                end
            end
            WAIT_ACT: begin
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_nxt   = '0;
                    state_nxt = ACCESS;
                end else begin
                    cnt_nxt = cnt_q - CNT_W'(1);
                end
            end
            ACCESS: begin
                valid_out = 1'b1;
                cmd_out   = write_q ? CMD_WRITE : CMD_READ;
                if (cmd_ready) begin
                    done_out  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state          <= IDLE;
            cnt_q          <= '0;
            open_q         <= '0;
            for (int i = 0; i < NUM_BANKS; i++) open_row_q[i] <= '0;
            write_q        <= 1'b0;
            idx_q          <= '0;
            bank_group_out <= '0;
            bank_out       <= '0;
            row_out        <= '0;
            col_out        <= '0;
        end else begin
            state <= state_nxt;
            cnt_q <= cnt_nxt;
            // Address outputs double as the held request, so they stay stable under backpressure.
            if (capture) begin
                write_q        <= req_write_in;
                idx_q          <= req_idx;
                bank_group_out <= req_bank_group_in;
                bank_out       <= req_bank_in;
                row_out        <= req_row_in;
                col_out        <= req_col_in;
            end
            if (state == PRECHARGE && cmd_ready)
                open_q[idx_q] <= 1'b0;
            if (state == ACTIVATE && cmd_ready) begin
                open_q[idx_q]     <= 1'b1;
                open_row_q[idx_q] <= row_out;
            end
        end
    end

endmodule

// File: tb/tb_bank_cmd_sequencer.sv
// Randomized bench for bank_cmd_sequencer: a bank-table model predicts the
// command sequence per request and the exact cycle each command may appear.
module tb_bank_cmd_sequencer;

    localparam int BG = 4, BPG = 2, RB = 8, CB = 4, ACT_LAT = 8, PRE_LAT = 5;
    localparam int BG_W = 2, BK_W = 1, NB = BG * BPG;
    localparam logic [2:0] C_NOP = 3'd0, C_ACT = 3'd1, C_RD = 3'd2, C_WR = 3'd3, C_PRE = 3'd4;

    logic            clk_in = 1'b0;
    logic            rst_in = 1'b1;
    logic            req_valid_in = 1'b0, req_ready_out, req_write_in = 1'b0;
    logic [BG_W-1:0] req_bank_group_in = '0;
    logic [BK_W-1:0] req_bank_in = '0;
    logic [RB-1:0]   req_row_in = '0;
    logic [CB-1:0]   req_col_in = '0;
    logic            cmd_ready = 1'b0, valid_out, done_out, busy_out;
    logic [2:0]      cmd_out;
    logic [BG_W-1:0] bank_group_out;
    logic [BK_W-1:0] bank_out;
    logic [RB-1:0]   row_out;
    logic [CB-1:0]   col_out;

    int total = 0, bad = 0;
    bit m_open [NB];
    int m_row  [NB];

    bank_cmd_sequencer #(
        .BANK_GROUPS(BG), .BANKS_PER_GROUP(BPG), .ROW_BITS(RB), .COL_BITS(CB),
        .ACTIVATION_LATENCY(ACT_LAT), .PRECHARGE_LATENCY(PRE_LAT)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
        .req_write_in(req_write_in), .req_bank_group_in(req_bank_group_in),
        .req_bank_in(req_bank_in), .req_row_in(req_row_in), .req_col_in(req_col_in),
        .cmd_ready(cmd_ready), .valid_out(valid_out), .cmd_out(cmd_out),
        .bank_group_out(bank_group_out), .bank_out(bank_out),
        .row_out(row_out), .col_out(col_out),
        .done_out(done_out), .busy_out(busy_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_model();
        foreach (m_open[i]) begin m_open[i] = 1'b0; m_row[i] = 0; end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, valid_out, 0);
        chk({tag, "_cmd"},   cmd_out, 0);
        chk({tag, "_busy"},  busy_out, 0);
        chk({tag, "_done"},  done_out, 0);
        chk({tag, "_addr"},  {bank_group_out, bank_out, row_out, col_out}, 0);
    endtask

    // One request end to end; cmd_ready is high with probability rdy_pct,
    // and bp_act forces three stalled cycles on the ACT command.
    task automatic do_req(input bit wr, input int bg, input int bk, input int row,
                          input int col, input int rdy_pct, input bit bp_act);
        logic [2:0] exp_cmd [3];
        int idx, n, k, cyc, due, hold;
        idx = bg * BPG + bk;
        n = 0;
        if (m_open[idx] && m_row[idx] != row) begin exp_cmd[n] = C_PRE; n++; end
        if (!(m_open[idx] && m_row[idx] == row)) begin exp_cmd[n] = C_ACT; n++; end
        exp_cmd[n] = wr ? C_WR : C_RD; n++;

        @(negedge clk_in);
        req_valid_in      = 1'b1;
        req_write_in      = wr;
        req_bank_group_in = BG_W'(bg);
        req_bank_in       = BK_W'(bk);
        req_row_in        = RB'(row);
        req_col_in        = CB'(col);
        #1;
        chk("idle_ready", req_ready_out, 1);
        chk("idle_busy", busy_out, 0);
        chk("idle_valid", valid_out, 0);
        @(posedge clk_in);

        k = 0; cyc = 0; due = 1; hold = 0;
        while (k < n) begin
            @(negedge clk_in);
            cyc++;
            req_valid_in      = 1'b0;
            req_write_in      = 1'($urandom);
            req_bank_group_in = BG_W'($urandom);
            req_bank_in       = BK_W'($urandom);
            req_row_in        = RB'($urandom);
            req_col_in        = CB'($urandom);
            if (cyc > 300) begin
                chk("timeout", 0, 1);
                break;
            end
            cmd_ready = ($urandom_range(99) < rdy_pct);
            if (bp_act && exp_cmd[k] == C_ACT && hold < 3) cmd_ready = 1'b0;
            #1;
            chk("busy", busy_out, 1);
            chk("ready_busy", req_ready_out, 0);
            if (cyc < due) begin
                chk("wait_valid", valid_out, 0);
                chk("wait_nop", cmd_out, C_NOP);
                chk("wait_done", done_out, 0);
            end else begin
                chk("cmd_valid", valid_out, 1);
                chk("cmd", cmd_out, exp_cmd[k]);
                chk("bg", bank_group_out, bg);
                chk("bank", bank_out, bk);
                chk("row", row_out, row);
                chk("col", col_out, col);
                chk("done", done_out, (cmd_ready && k == n - 1) ? 1 : 0);
                if (cmd_ready) begin
                    if (exp_cmd[k] == C_PRE) begin
                        m_open[idx] = 1'b0;
                        due = cyc + PRE_LAT;
                    end else if (exp_cmd[k] == C_ACT) begin
                        m_open[idx] = 1'b1;
                        m_row[idx]  = row;
                        due = cyc + ACT_LAT;
                    end
                    k++;
                    hold = 0;
                end else begin
                    hold++;
                end
            end
        end
        @(posedge clk_in);
    endtask

    initial begin
        clear_model();
        repeat (3) @(negedge clk_in);
        #1;
        chk_reset_outputs("rst_hold");
        rst_in = 1'b0;
        @(negedge clk_in);
        #1;
        chk("rst_ready", req_ready_out, 1);

        do_req(1, 3, 1, 'h55, 'hA, 100, 0);   // closed bank
        do_req(0, 3, 1, 'h55, 'h6, 100, 0);   // row hit
        do_req(0, 3, 1, 'h0F, 'h3, 100, 0);   // row conflict
        do_req(0, 3, 1, 'h0F, 'h4, 100, 0);   // hit on new row
        do_req(1, 0, 0, 'h12, 'h1, 100, 1);   // ACT backpressure
        do_req(1, 2, 1, 'hF0, 'h2, 100, 0);   // isolation
        do_req(0, 3, 1, 'h55, 'h5, 100, 0);
        do_req(0, 2, 1, 'hF0, 'h9, 100, 0);

        // reset while ACT is stalled on the bus
        @(negedge clk_in);
        req_valid_in = 1'b1; req_write_in = 1'b0; req_bank_group_in = 2'd1;
        req_bank_in = 1'b0; req_row_in = 8'h33; req_col_in = 4'h1; cmd_ready = 1'b0;
        @(posedge clk_in);
        @(negedge clk_in);
        req_valid_in = 1'b0;
        #1;
        chk("stall_valid", valid_out, 1);
        chk("stall_cmd", cmd_out, C_ACT);
        #1 rst_in = 1'b1;
        #1 chk_reset_outputs("rst_act");
        @(negedge clk_in);
        rst_in = 1'b0;
        clear_model();
        #1 chk("rst_act_ready", req_ready_out, 1);

        // reset in the middle of the activation wait
        @(negedge clk_in);
        req_valid_in = 1'b1; cmd_ready = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        req_valid_in = 1'b0;
        @(posedge clk_in);
        @(negedge clk_in);
        #1;
        chk("wact_busy", busy_out, 1);
        chk("wact_valid", valid_out, 0);
        #1 rst_in = 1'b1;
        #1 chk_reset_outputs("rst_wact");
        @(negedge clk_in);
        rst_in = 1'b0;
        clear_model();
        do_req(0, 1, 0, 'h33, 'h2, 100, 0);   // table cleared, so ACT again
        do_req(0, 3, 1, 'h55, 'h2, 100, 0);

        for (int i = 0; i < 40; i++) begin
            int sel, row;
            sel = int'($urandom_range(3));
            row = (sel == 0) ? 'h55 : (sel == 1) ? 'h0F : (sel == 2) ? 'hF0 : int'($urandom_range(255));
            do_req(1'($urandom), int'($urandom_range(BG - 1)), int'($urandom_range(BPG - 1)),
                   row, int'($urandom_range(15)), 65, 1'($urandom_range(3) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
